// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: holds MAR/MDR and sequences fixed-wait SRAM read/write
// cycles, giving the control FSM a BUSY/DONE handshake.
module mem_bus_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] BUS_IN,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] MEM_DIN,
    output logic [15:0] MAR_OUT,
    output logic [15:0] MDR_OUT,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_DOUT,
    output logic        MEM_CE_N,
    output logic        MEM_OE_N,
    output logic        MEM_WE_N,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [15:0] mar_r, mar_s;
    logic [15:0] mdr_r, mdr_s;
    logic        ce_n_r, oe_n_r, we_n_r, busy_r, done_r;
    logic        ce_n_s, oe_n_s, we_n_s, busy_s, done_s;

    // Next-state, counter and MAR/MDR load logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        mar_s   = mar_r;
        mdr_s   = mdr_r;
        case (state_r)
            ST_IDLE: begin
                if (LD_MAR) mar_s = BUS_IN;
                else        mar_s = mar_r;
                if (LD_MDR) mdr_s = BUS_IN;
                else        mdr_s = mdr_r;
                if (MEM_REQ) begin
                    state_s = MEM_WE ? ST_WRITE : ST_READ;
                    cnt_s   = CNT_INIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ, ST_WRITE: begin
                if (cnt_r != 4'd0) begin
                    cnt_s = cnt_r - 4'd1;
                end else begin
                    // Read data is captured only on the last strobe cycle.
                    if (state_r == ST_READ) mdr_s = MEM_DIN;
                    else                    mdr_s = mdr_r;
                    state_s = ST_DONE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Strobe and handshake decode of the next state, so the outputs come straight from flops.
    always_comb begin
        ce_n_s = ~((state_s == ST_READ) || (state_s == ST_WRITE));
        oe_n_s = ~(state_s == ST_READ);
        we_n_s = ~(state_s == ST_WRITE);
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath registers and registered strobes; reset releases the SRAM at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            mar_r   <= 16'h0000;
            mdr_r   <= 16'h0000;
            ce_n_r  <= 1'b1;
            oe_n_r  <= 1'b1;
            we_n_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            mar_r   <= mar_s;
            mdr_r   <= mdr_s;
            ce_n_r  <= ce_n_s;
            oe_n_r  <= oe_n_s;
            we_n_r  <= we_n_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign MAR_OUT  = mar_r;
    assign MDR_OUT  = mdr_r;
    assign MEM_ADDR = mar_r;
    assign MEM_DOUT = mdr_r;
    assign MEM_CE_N = ce_n_r;
    assign MEM_OE_N = oe_n_r;
    assign MEM_WE_N = we_n_r;
    assign BUSY     = busy_r;
    assign DONE     = done_r;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: transaction-level timing model checked every cycle,
// an SRAM model, and directed scenarios with literal expectations.
module tb_mem_bus_ctrl;

    localparam int WC = 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] BUS_IN = 16'h0000;
    logic        LD_MAR = 1'b0;
    logic        LD_MDR = 1'b0;
    logic        MEM_REQ = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [15:0] mem_din;
    logic [15:0] MAR_OUT, MDR_OUT, MEM_ADDR, MEM_DOUT;
    logic        MEM_CE_N, MEM_OE_N, MEM_WE_N, BUSY, DONE;

    mem_bus_ctrl #(.WAIT_CYCLES(WC)) dut (
        .Clk(Clk), .Reset(Reset), .BUS_IN(BUS_IN), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_DIN(mem_din),
        .MAR_OUT(MAR_OUT), .MDR_OUT(MDR_OUT), .MEM_ADDR(MEM_ADDR), .MEM_DOUT(MEM_DOUT),
        .MEM_CE_N(MEM_CE_N), .MEM_OE_N(MEM_OE_N), .MEM_WE_N(MEM_WE_N),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 Clk = ~Clk;

    // SRAM model, folded to 256 words by address nibbles.
    logic [15:0] sram [0:255];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [15:0] pl_data = 16'h0000;

    function automatic logic [7:0] idx(input logic [15:0] a);
        return {a[15:12], a[3:0]};
    endfunction

    always @(negedge Clk) begin
        if (pl_en) sram[idx(pl_addr)] <= pl_data;
        else if (!MEM_CE_N && !MEM_WE_N) sram[idx(MEM_ADDR)] <= MEM_DOUT;
        mem_din <= sram[idx(MEM_ADDR)];
    end

    // Strobe and pulse counters, sampled just after each rising edge.
    int oe_cnt = 0, we_cnt = 0, done_cnt = 0;
    always @(posedge Clk) begin
        #1;
        if (!MEM_OE_N) oe_cnt <= oe_cnt + 1;
        if (!MEM_WE_N) we_cnt <= we_cnt + 1;
        if (DONE)      done_cnt <= done_cnt + 1;
    end

    // Behavioural model: an access accepted at the edge ending cycle s strobes in
    // cycles s+1..s+WC and signals DONE in cycle s+WC+1.
    int          cyc = 0;
    int          acc_start = -1000;
    bit          m_wr = 1'b0;
    logic [15:0] m_mar = 16'h0000;
    logic [15:0] m_mdr = 16'h0000;

    function automatic bit in_access(input int c, input int s);
        return (c > s) && (c <= s + WC + 1);
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_mar     <= 16'h0000;
            m_mdr     <= 16'h0000;
            acc_start <= -1000;
            m_wr      <= 1'b0;
        end else begin
            if (!in_access(cyc, acc_start)) begin
                if (LD_MAR) m_mar <= BUS_IN;
                if (LD_MDR) m_mdr <= BUS_IN;
                if (MEM_REQ) begin
                    acc_start <= cyc;
                    m_wr      <= MEM_WE;
                end
            end else if (!m_wr && (cyc == acc_start + WC)) begin
                m_mdr <= mem_din;
            end
            cyc <= cyc + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_check();
        bit strobe_e, done_e;
        strobe_e = (cyc > acc_start) && (cyc <= acc_start + WC);
        done_e   = (cyc == acc_start + WC + 1);
        chk("mar_out",  MAR_OUT,  m_mar);
        chk("mdr_out",  MDR_OUT,  m_mdr);
        chk("mem_addr", MEM_ADDR, m_mar);
        chk("mem_dout", MEM_DOUT, m_mdr);
        chk("ce_n", {15'd0, MEM_CE_N}, {15'd0, !strobe_e});
        chk("oe_n", {15'd0, MEM_OE_N}, {15'd0, !(strobe_e && !m_wr)});
        chk("we_n", {15'd0, MEM_WE_N}, {15'd0, !(strobe_e && m_wr)});
        chk("busy", {15'd0, BUSY}, {15'd0, (strobe_e || done_e)});
        chk("done", {15'd0, DONE}, {15'd0, done_e});
    endtask

    task automatic tick();
        @(negedge Clk);
        model_check();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (DONE !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("done_seen", {15'd0, DONE}, 16'h0001);
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge Clk);
        #1;
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge Clk);
        #1;
        pl_en = 1'b0;
    endtask

    int n, oe0, we0, dn0;

    initial begin
        Reset = 1'b0;
        preload(16'h3000, 16'h8001);
        preload(16'h5000, 16'h7E7E);
        preload(16'h6000, 16'hBEEF);
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        chk("rst_mar", MAR_OUT, 16'h0000);
        chk("rst_mdr", MDR_OUT, 16'h0000);
        chk("rst_strobes", {13'd0, MEM_CE_N, MEM_OE_N, MEM_WE_N}, 16'h0007);
        chk("rst_busy_done", {14'd0, BUSY, DONE}, 16'h0000);

        BUS_IN = 16'hFFFF; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0;
        chk("ld_mar_ffff", MAR_OUT, 16'hFFFF);

        // Read 3000
        BUS_IN = 16'h3000; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0; MEM_REQ = 1'b1; MEM_WE = 1'b0;
        oe0 = oe_cnt; dn0 = done_cnt;
        tick();
        MEM_REQ = 1'b0;
        wait_done(n);
        chk_int("read_latency", n, 2);
        chk("read_mdr", MDR_OUT, 16'h8001);
        tick();
        chk_int("read_oe_cycles", oe_cnt - oe0, 2);
        chk_int("read_done_pulses", done_cnt - dn0, 1);

        // Write 00A5 to 4000 with MDR loaded alongside the request
        BUS_IN = 16'h4000; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0; BUS_IN = 16'h00A5; LD_MDR = 1'b1; MEM_REQ = 1'b1; MEM_WE = 1'b1;
        oe0 = oe_cnt; we0 = we_cnt;
        tick();
        LD_MDR = 1'b0; MEM_REQ = 1'b0; MEM_WE = 1'b0;
        chk("wr_we_n", {15'd0, MEM_WE_N}, 16'h0000);
        chk("wr_addr", MEM_ADDR, 16'h4000);
        chk("wr_dout", MEM_DOUT, 16'h00A5);
        wait_done(n);
        chk_int("write_latency", n, 2);
        tick();
        chk_int("write_we_cycles", we_cnt - we0, 2);
        chk_int("write_oe_cycles", oe_cnt - oe0, 0);
        chk("sram_4000", sram[idx(16'h4000)], 16'h00A5);
        MEM_REQ = 1'b1;
        tick();
        MEM_REQ = 1'b0;
        wait_done(n);
        chk("readback_4000", MDR_OUT, 16'h00A5);
        tick();

        // Loads attempted mid-read are ignored
        BUS_IN = 16'h5000; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0; MEM_REQ = 1'b1;
        tick();
        MEM_REQ = 1'b0; LD_MAR = 1'b1; BUS_IN = 16'h1234;
        chk("mid_addr1", MEM_ADDR, 16'h5000);
        tick();
        LD_MAR = 1'b0; LD_MDR = 1'b1; BUS_IN = 16'h5555;
        chk("mid_addr2", MEM_ADDR, 16'h5000);
        tick();
        LD_MDR = 1'b0;
        chk("mid_done", {15'd0, DONE}, 16'h0001);
        chk("mid_mdr", MDR_OUT, 16'h7E7E);
        tick();
        chk("mid_mar_after", MAR_OUT, 16'h5000);

        // Request while busy is dropped; request in the following idle cycle is taken
        MEM_REQ = 1'b1; MEM_WE = 1'b0;
        dn0 = done_cnt;
        tick();
        MEM_REQ = 1'b1;
        tick();
        MEM_REQ = 1'b0;
        tick();
        chk("busy_req_done", {15'd0, DONE}, 16'h0001);
        tick();
        chk("busy_req_idle", {15'd0, BUSY}, 16'h0000);
        chk_int("busy_req_pulses", done_cnt - dn0, 1);
        MEM_REQ = 1'b1;
        tick();
        MEM_REQ = 1'b0;
        chk("after_done_busy", {15'd0, BUSY}, 16'h0001);
        wait_done(n);
        chk_int("after_done_latency", n, 2);
        tick();

        // Asynchronous reset in the second strobe cycle of a read of 6000
        BUS_IN = 16'h6000; LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0; MEM_REQ = 1'b1;
        dn0 = done_cnt;
        tick();
        MEM_REQ = 1'b0;
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_strobes", {13'd0, MEM_CE_N, MEM_OE_N, MEM_WE_N}, 16'h0007);
        chk("arst_busy", {15'd0, BUSY}, 16'h0000);
        chk("arst_mdr", MDR_OUT, 16'h0000);
        chk("arst_mar", MAR_OUT, 16'h0000);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        tick();
        tick();
        chk_int("arst_no_done", done_cnt - dn0, 0);
        chk("arst_idle", {15'd0, BUSY}, 16'h0000);
        chk("arst_mdr_after", MDR_OUT, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side datapath stage directly upstream of the condition-code/branch logic.
- Holds MAR and MDR and sequences SRAM read/write cycles with a fixed wait-state count.
- Drives MDR_OUT onto the 16-bit CPU bus; that bus value feeds NZP generation.
- Gives the control FSM a BUSY/DONE handshake, so the FSM no longer hard-codes memory wait states.

Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM strobe is held per access; legal range 1..15.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- BUS_IN  input  16  CPU bus value; source for MAR and for MDR bus loads.
- LD_MAR  input  1  load MAR from BUS_IN.
- LD_MDR  input  1  load MDR from BUS_IN.
- MEM_REQ  input  1  start a memory access; sampled in IDLE only.
- MEM_WE  input  1  access type, sampled with MEM_REQ: 1 = write, 0 = read.
- MEM_DIN  input  16  read data from SRAM.
- MAR_OUT  output  16  current MAR.
- MDR_OUT  output  16  current MDR, to the bus mux.
- MEM_ADDR  output  16  SRAM address; always equals MAR.
- MEM_DOUT  output  16  SRAM write data; always equals MDR.
- MEM_CE_N  output  1  SRAM chip enable, active-low.
- MEM_OE_N  output  1  SRAM output enable, active-low.
- MEM_WE_N  output  1  SRAM write enable, active-low.
- BUSY  output  1  high while an access is in progress (state READ, WRITE or DONE).
- DONE  output  1  one-cycle pulse marking completion of an access.

Behaviour:
- Reset (asynchronous, Reset=0):
  - MAR, MDR, counter = 0; state = IDLE.
  - MEM_CE_N = MEM_OE_N = MEM_WE_N = 1; BUSY = DONE = 0.
  - Strobes deassert immediately, mid-access included. No partial MDR update.
- FSM states: IDLE, READ, WRITE, DONE.
  - IDLE:
    - MEM_REQ=1 at an edge → READ if MEM_WE=0, WRITE if MEM_WE=1; counter ← WAIT_CYCLES-1.
    - MEM_REQ=0 → stay in IDLE.
  - READ: CE_N=0, OE_N=0, WE_N=1.
    - Each edge with counter≠0: decrement.
    - Edge with counter=0: MDR ← MEM_DIN; → DONE.
  - WRITE: CE_N=0, WE_N=0, OE_N=1.
    - Counter behaves as in READ; at counter=0 → DONE.
    - MDR is unchanged.
  - DONE: all strobes high, DONE=1 for exactly one cycle, BUSY=1; next edge → IDLE.
- Latency:
  - Request sampled at edge k → strobes low in cycles k+1..k+WAIT_CYCLES.
  - DONE high in cycle k+WAIT_CYCLES+1; read data is visible on MDR_OUT in that cycle.
  - A new MEM_REQ is accepted at the edge ending the first IDLE cycle after DONE, i.e. no back-to-back acceptance from DONE.
- Register loads:
  - LD_MAR and LD_MDR take effect only in IDLE; they are ignored while BUSY=1 so address and data stay stable under the strobe.
  - MEM_REQ and LD_MAR asserted in the same IDLE cycle: MAR loads at that edge; the access uses the new MAR from its first strobe cycle.
  - MEM_REQ and LD_MDR in the same IDLE cycle on a write: MDR loads at that edge; the access writes the new MDR value.
  - MEM_REQ and LD_MDR in the same IDLE cycle on a read: MDR loads from the bus, then is overwritten by MEM_DIN at read completion.
- MEM_REQ while BUSY=1 is ignored, not queued. MEM_WE is don't-care outside request sampling.
- Strobes are registered-state decodes only: glitch-free, and CE_N never low in IDLE or DONE.
- Counter width: 4 bits. WAIT_CYCLES=1 gives a single strobe cycle with no decrement.

Test Plan:
- Reset release → MAR=MDR=0, all strobes 1, BUSY=0, DONE=0; BUS_IN=16'hFFFF with LD_MAR=1 → MAR_OUT=16'hFFFF next cycle.
- Read, WAIT_CYCLES=2:
  - Stimulus: BUS_IN=16'h3000 with LD_MAR, then MEM_REQ=1, MEM_WE=0; model returns MEM_DIN=16'h8001 at addr 3000.
  - Required: OE_N/CE_N low for exactly 2 cycles, DONE high on 3rd cycle after request edge, MDR_OUT=16'h8001.
- Write:
  - Stimulus: MAR=16'h4000, LD_MDR with BUS_IN=16'h00A5, MEM_REQ=1, MEM_WE=1.
  - Required: WE_N low 2 cycles with MEM_ADDR=16'h4000 and MEM_DOUT=16'h00A5, OE_N stays 1, subsequent read of 4000 returns 16'h00A5.
- Mid-access loads: during READ assert LD_MAR with BUS_IN=16'h1234 and LD_MDR with 16'h5555 → MEM_ADDR holds old value through the strobe, MAR unchanged after DONE, MDR = memory data.
- Request during BUSY: second MEM_REQ pulse in cycle k+1 → no second access, exactly one DONE pulse; a request in the IDLE cycle after DONE starts a new access.
- Reset mid-access: drive Reset=0 in the 2nd strobe cycle of a read with MEM_DIN=16'hBEEF → strobes go to 1 without waiting for a clock edge, MDR=0, no DONE pulse, state IDLE after release.
